fft_out_serializer: RTL and testbench

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_grp_fifo.sv | 63 ++++++
 rtl/fft_out_serializer.sv | 132 +++++++++++++
 tb/tb_fft_out_serializer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output path.
// Contents: frame/lane geometry constants, the complex sample type and a
// helper that extracts one point (lane) from a packed 8-point group.
package fft_pkg;

    localparam int FFT_POINTS = 16;            // frame length used for start-of-frame marking
    localparam int FFT_LANES  = 8;             // points delivered per input group
    localparam int SAMPLE_W   = 16;            // width of each real/imag component
    localparam int POINT_W    = 2 * SAMPLE_W;  // packed {real, imag}
    localparam int LANE_W     = $clog2(FFT_LANES);

    // Signed 8.8 fixed point complex sample, real part in the upper half.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] real_part;
        logic signed [SAMPLE_W-1:0] imag_part;
    } cplx_t;

    // Lane 0 occupies the least significant point slot of a packed group.
    function automatic cplx_t grp_lane(input logic [FFT_LANES*POINT_W-1:0] grp,
                                       input logic [LANE_W-1:0]            lane);
        return cplx_t'(grp[int'(lane)*POINT_W +: POINT_W]);
    endfunction

endpackage

// File: rtl/fft_grp_fifo.sv
// Group FIFO: stores whole 8-point groups together with their base index.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, wr_data       write one entry (caller guarantees space or a same-cycle pop)
//   pop                 retire the head entry (caller guarantees count > 0)
//   head_data           entry at the read pointer
//   next_data           entry behind the head, used when the head retires
//   count               number of stored entries (0..DEPTH)
module fft_grp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 266
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage array; contents are don't-care until counted, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign next_data = mem_r[rd_ptr_r + PTR_W'(1)];
    assign count     = count_r;

endmodule

// File: rtl/fft_out_serializer.sv
// FFT output serializer: buffers 8-point groups and emits them one point per
// ready/valid handshake, tagging each point with its stream index.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fft_valid, fft_d0..d7    one 8-point group per valid cycle, d0 lowest index
//   out_ready                downstream accepts the current point
//   out_valid                a point is presented on out_real/imag/index/sof
//   out_real, out_imag       current point, bit-exact copy of the input
//   out_index                stream position modulo 2^IDX_W
//   out_sof                  current point is bin 0 of a 16-point frame
//   overflow                 sticky flag: a group was dropped since reset
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int GRP_DEPTH = 4,
    parameter int IDX_W     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fft_valid,
    input  logic [31:0]         fft_d0,
    input  logic [31:0]         fft_d1,
    input  logic [31:0]         fft_d2,
    input  logic [31:0]         fft_d3,
    input  logic [31:0]         fft_d4,
    input  logic [31:0]         fft_d5,
    input  logic [31:0]         fft_d6,
    input  logic [31:0]         fft_d7,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [15:0]         out_real,
    output logic [15:0]         out_imag,
    output logic [IDX_W-1:0]    out_index,
    output logic                out_sof,
    output logic                overflow
);

    localparam int GRP_W = FFT_LANES * POINT_W;
    localparam int ENT_W = GRP_W + IDX_W;
    localparam int CNT_W = $clog2(GRP_DEPTH) + 1;
    localparam int SOF_W = $clog2(FFT_POINTS);

    logic [CNT_W-1:0]  count_s;
    logic [ENT_W-1:0]  head_s;
    logic [ENT_W-1:0]  next_s;
    logic [ENT_W-1:0]  wr_ent_s;
    logic [ENT_W-1:0]  src_s;
    logic [LANE_W-1:0] sub_r;
    logic [LANE_W-1:0] sub_nxt_s;
    logic [IDX_W-1:0]  wr_base_r;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic              adv_s;
    logic              pop_s;
    logic              push_s;
    logic              empty_after_pop_s;
    logic              load_s;
    cplx_t             pt_s;

    fft_grp_fifo #(
        .DEPTH (GRP_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .wr_data   (wr_ent_s),
        .head_data (head_s),
        .next_data (next_s),
        .count     (count_s)
    );

    // Handshake decode and selection of the point to present after this edge.
    // Outputs are registered, so the next head point is computed here; when
    // the buffer drains to empty the incoming group is forwarded directly.
    always_comb begin
        adv_s             = out_valid & out_ready;
        pop_s             = adv_s & (sub_r == LANE_W'(FFT_LANES - 1));
        push_s            = fft_valid & ((count_s < CNT_W'(GRP_DEPTH)) | pop_s);
        empty_after_pop_s = (count_s == {{(CNT_W-1){1'b0}}, pop_s});
        wr_ent_s          = {wr_base_r, fft_d7, fft_d6, fft_d5, fft_d4,
                             fft_d3, fft_d2, fft_d1, fft_d0};
        load_s            = 1'b1;
        src_s             = head_s;
        sub_nxt_s         = sub_r;
        if (empty_after_pop_s) begin
            src_s     = wr_ent_s;
            sub_nxt_s = {LANE_W{1'b0}};
            load_s    = push_s;
        end else if (pop_s) begin
            src_s     = next_s;
            sub_nxt_s = {LANE_W{1'b0}};
        end else if (adv_s) begin
            sub_nxt_s = sub_r + LANE_W'(1);
        end else begin
            sub_nxt_s = sub_r;
        end
        pt_s      = grp_lane(src_s[GRP_W-1:0], sub_nxt_s);
        idx_nxt_s = src_s[ENT_W-1:GRP_W] + IDX_W'(sub_nxt_s);
    end

    // Serializer state and registered output point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_r     <= {LANE_W{1'b0}};
            wr_base_r <= {IDX_W{1'b0}};
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_real  <= 16'd0;
            out_imag  <= 16'd0;
            out_index <= {IDX_W{1'b0}};
            out_sof   <= 1'b0;
        end else begin
            // Dropped groups still consume their 8 index values.
            if (fft_valid) begin
                wr_base_r <= wr_base_r + IDX_W'(FFT_LANES);
            end
            if (fft_valid && !push_s) begin
                overflow <= 1'b1;
            end
            sub_r     <= sub_nxt_s;
            out_valid <= !empty_after_pop_s || push_s;
            if (load_s) begin
                out_real  <= pt_s.real_part;
                out_imag  <= pt_s.imag_part;
                out_index <= idx_nxt_s;
                out_sof   <= (idx_nxt_s[SOF_W-1:0] == SOF_W'(0));
            end
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer. The reference model is a queue
// of expected output points; buffer occupancy is derived from the number of
// outstanding points (groups = ceil(points/8)).
module tb_fft_out_serializer;

    localparam int DEPTH = 4;
    localparam int IW    = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fft_valid = 1'b0;
    logic [31:0] fft_d0 = 32'd0, fft_d1 = 32'd0, fft_d2 = 32'd0, fft_d3 = 32'd0;
    logic [31:0] fft_d4 = 32'd0, fft_d5 = 32'd0, fft_d6 = 32'd0, fft_d7 = 32'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic [IW-1:0] out_index;
    logic        out_sof;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0]   din [8];
    logic [31:0]   gold [1024];
    logic [41:0]   exp_q [$];      // {index, point}
    logic          exp_ovf = 1'b0;
    logic [IW-1:0] exp_base = '0;
    logic [44:0]   obs;

    fft_out_serializer #(.GRP_DEPTH(DEPTH), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(fft_d0), .fft_d1(fft_d1), .fft_d2(fft_d2), .fft_d3(fft_d3),
        .fft_d4(fft_d4), .fft_d5(fft_d5), .fft_d6(fft_d6), .fft_d7(fft_d7),
        .out_ready(out_ready), .out_valid(out_valid), .out_real(out_real),
        .out_imag(out_imag), .out_index(out_index), .out_sof(out_sof),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Expected {valid, overflow, index, real, imag, sof}; fields zero when idle.
    function automatic logic [44:0] exp_obs();
        logic [41:0] e;
        if (exp_q.size() == 0) return {1'b0, exp_ovf, 43'd0};
        e = exp_q[0];
        return {1'b1, exp_ovf, e[41:32], e[31:16], e[15:0], (e[35:32] == 4'd0)};
    endfunction

    // Drive one cycle of stimulus, advance the model, wait for the edge.
    task automatic step(input bit v, input bit rdy);
        int  n;
        bit  xfer;
        bit  acc;
        fft_valid = v;
        out_ready = rdy;
        fft_d0 = din[0]; fft_d1 = din[1]; fft_d2 = din[2]; fft_d3 = din[3];
        fft_d4 = din[4]; fft_d5 = din[5]; fft_d6 = din[6]; fft_d7 = din[7];
        n    = exp_q.size();
        xfer = (n > 0) && rdy;
        acc  = v && ((((n + 7) / 8) < DEPTH) || (xfer && (n % 8 == 1)));
        if (xfer) void'(exp_q.pop_front());
        if (acc) begin
            for (int k = 0; k < 8; k++) exp_q.push_back({exp_base + IW'(k), din[k]});
        end else if (v) begin
            exp_ovf = 1'b1;
        end
        if (v) exp_base = exp_base + IW'(8);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fft_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_base = '0;
    endtask

    task automatic rand_din();
        for (int k = 0; k < 8; k++) din[k] = $urandom;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, out_real, out_imag, out_index, out_sof, overflow} !== 45'd0) begin
            errors++;
            $display("FAIL reset_state got v%b r%h i%h x%0d s%b o%b exp all zero",
                     out_valid, out_real, out_imag, out_index, out_sof, overflow);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k < 8; k++) din[k] = 32'h0001_0002 + 32'h0001_0001 * 32'(k);
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            obs = {out_valid, overflow, out_valid ? {out_index, out_real, out_imag, out_sof} : 43'd0};
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL single cyc%0d got %h exp %h", c, obs, exp_obs());
            end
            step(c == 0, 1'b1);
        end
    endtask

    task automatic test_stream(input bit rand_ready, input int spacing);
        int g = 0;
        do_reset();
        for (int c = 0; c < 128 * spacing + 200; c++) begin
            bit v;
            bit r;
            if (c > 0) @(negedge clk);
            obs = {out_valid, overflow, out_valid ? {out_index, out_real, out_imag, out_sof} : 43'd0};
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL stream rr%0d cyc%0d got %h exp %h", rand_ready, c, obs, exp_obs());
            end
            v = (g < 128) && (c % spacing == 0);
            if (v) begin
                for (int k = 0; k < 8; k++) din[k] = gold[g * 8 + k];
                g++;
            end
            r = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(v, r);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL stream_end rr%0d left %0d ovf %b exp 0 0", rand_ready, exp_q.size(), overflow);
        end
    endtask

    task automatic test_overflow();
        bit seen40 = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            obs = {out_valid, overflow, out_valid ? {out_index, out_real, out_imag, out_sof} : 43'd0};
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL ovf_fill cyc%0d got %h exp %h", c, obs, exp_obs());
            end
            rand_din();
            step(1'b1, 1'b0);
        end
        rand_din();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            obs = {out_valid, overflow, out_valid ? {out_index, out_real, out_imag, out_sof} : 43'd0};
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL ovf_drain cyc%0d got %h exp %h", c, obs, exp_obs());
            end
            if (out_valid && out_index == IW'(40)) seen40 = 1'b1;
            step(c == 32, 1'b1);
        end
        checks++;
        if (!seen40 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_next_base seen40 %b ovf %b exp 1 1", seen40, overflow);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int c = 0; c < 30; c++) begin
            bit v;
            bit r;
            if (c > 0) @(negedge clk);
            obs = {out_valid, overflow, out_valid ? {out_index, out_real, out_imag, out_sof} : 43'd0};
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL full_pop cyc%0d got %h exp %h", c, obs, exp_obs());
            end
            // cycles 0..3 fill, 4..10 drain 7 points, 11 pops 8th with a new group
            v = (c < 4) || (c == 11);
            r = (c >= 4);
            rand_din();
            step(v, r);
        end
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_ovf got %b exp 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            obs = {out_valid, overflow, out_valid ? {out_index, out_real, out_imag, out_sof} : 43'd0};
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL rst_mid_pre cyc%0d got %h exp %h", c, obs, exp_obs());
            end
            rand_din();
            step(c < 2, c >= 2);
        end
        @(negedge clk);
        rst = 1'b1;
        fft_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_real, out_imag, out_index, out_sof, overflow} !== 45'd0) begin
            errors++;
            $display("FAIL rst_mid_async got v%b x%0d exp all zero", out_valid, out_index);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fft_valid = 1'b0;
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_base = '0;
        rand_din();
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            obs = {out_valid, overflow, out_valid ? {out_index, out_real, out_imag, out_sof} : 43'd0};
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL rst_mid_post cyc%0d got %h exp %h", c, obs, exp_obs());
            end
            step(c == 0, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) gold[i] = $urandom;
        for (int k = 0; k < 8; k++) din[k] = 32'd0;
        test_reset();
        test_single();
        test_stream(1'b0, 8);
        test_overflow();
        test_full_pop();
        test_stream(1'b1, 16);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
